hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It keeps a small scoreboard of in-flight destination registers and their remaining result latency (Tnew) for the E, M and W stages. From that scoreboard it produces the stall that freezes PC/F-D and flushes the D/E pipeline register, plus the forwarding selects for D, E and M. It also owns the mult/div busy counter that sequences HI/LO access.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu after leaving E
DIV_CYCLES, 10, busy cycles for div/divu after leaving E

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high; clears scoreboard and counter
rs_D  input  5  D-stage rs address
rt_D  input  5  D-stage rt address
tuse_rs_D  input  2  cycles until rs needed (0=D, 1=E, 2=M, 3=unused)
tuse_rt_D  input  2  same for rt
wa_D  input  5  D-stage destination register (0 = none)
tnew_D  input  2  result latency counted from E entry (0=PC8/jal, 1=ALU, 2=load)
md_op_D  input  2  0 none, 1 mult, 2 div
md_use_D  input  1  D instruction reads/writes HI/LO or starts mult/div
stall  output  1  freeze PC and F/D; flush D/E
fwd_rs_D  output  2  D compare operand select: 0 GRF, 1 W, 2 M, 3 E
fwd_rt_D  output  2  as above
fwd_rs_E  output  2  E ALU operand: 0 pipe value, 1 W, 2 M
fwd_rt_E  output  2  as above
fwd_rt_M  output  1  M store data: 0 pipe value, 1 W
md_busy  output  1  mult/div unit busy

Behaviour:
- Clock is clk; reset is asynchronous and active-high. Both are fixed for this block.
- Scoreboard records:
  - E: {rs, rt, wa, tnew, md_op}
  - M: {rt, wa, tnew}
  - W: {wa}
- Each record updates on posedge clk.
- Reset: all records and the counter clear to 0 immediately. While records are zero, every output is 0.
- Advance with no stall:
  - E ← D fields.
  - M ← E, with tnew = saturating (tnew_E − 1), floor 0.
  - W ← M wa. The W record is always tnew 0.
- Advance with stall: the E record loads a bubble (all fields 0). M and W advance normally. D is held externally.
- stall (combinational) asserts when any of the following holds:
  - Register hazard: for r ∈ {rs, rt} with r_D ≠ 0 and tuse ≠ 3:
    - (wa_E == r_D && tnew_E > tuse), or
    - (wa_M == r_D && tnew_M > tuse).
  - MD hazard: md_use_D && (md_busy || md_op_E ≠ 0).
- Forwarding rules:
  - A source is eligible only when its address is nonzero, matches, and its tnew is 0.
  - D-stage priority: E, then M, then W, then GRF.
  - E-stage priority: M, then W.
  - M-stage: W only.
  - $0 is never forwarded.
- MD counter (cnt, 4 bits):
  - Loads MULT_CYCLES or DIV_CYCLES at the edge where md_op_E ≠ 0 leaves E.
  - Otherwise decrements to 0.
  - md_busy = (cnt ≠ 0).
  - A new load while busy cannot occur, because the MD hazard stalls it. If both a load and a decrement apply in the same cycle, the load wins.
- Mid-operation reset: cnt returns to 0 and md_busy deasserts asynchronously. No pending stall survives the reset.
- Latency: every output is combinational from inputs and the current records. No output is registered.

Decomposition:
- hazard_pkg holds:
  - widths of tnew/tuse
  - the TUSE_NONE=3 constant
  - FWD_GRF/W/M/E encodings
  - MD_NONE/MULT/DIV codes
- Sub-module md_busy_counter holds the counter, load and decrement logic. Its ports are clk, reset, md_op_E, md_busy.

Test Plan:
- Load-use (lw $1, then add $2,$1,$3):
  - Cycle 1: E{wa=1,tnew=2}, D rs=1, tuse=1 → stall=1 for 1 cycle.
  - Next cycle: M{tnew=1} → stall=0.
  - When add is in E: fwd_rs_E=1 (W).
- ALU-branch (add $4, then beq $4,$0):
  - tnew_E=1, tuse 0 → stall=1.
  - Next cycle: fwd_rs_D=2 (M), stall=0.
- jal then jr $31: E{wa=31,tnew=0} → stall=0, fwd_rs_D=3 (E).
- mult then mfhi:
  - stall=1 while mult is in E, then for 5 busy cycles (6 consecutive cycles).
  - md_busy high for 5 cycles.
  - stall=0 once cnt=0.
- $0 destination: wa_D=0, tnew=2, followed by a use of rs=0 → stall=0 and all fwd selects 0.
- Reset asserted asynchronously mid-div (cnt=7): md_busy, stall and all selects drop to 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency/forwarding select codes, mult/div op codes, and the
// saturating Tnew decrement used as a record moves from E to M.
package hazard_pkg;

  localparam int LAT_W = 2;
  typedef logic [LAT_W-1:0] lat_t;

  // tuse value meaning "operand not read by this instruction"
  localparam lat_t TUSE_NONE = 2'd3;

  // forwarding select encodings (E-stage and M-stage use the low codes)
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_W   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_E   = 2'd3;

  // mult/div operation codes carried with the instruction
  localparam logic [1:0] MD_NONE = 2'd0;
  localparam logic [1:0] MD_MULT = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;

  // one cycle closer to having its result; never goes below zero
  function automatic lat_t tnew_dec(input lat_t t);
    return (t == '0) ? '0 : lat_t'(t - 1'b1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy counter: loads the op latency as a mult/div leaves E.
// md_busy is combinational from the count; the count is registered.
// No backpressure of its own; the hazard stall keeps a second load out.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op_E,
  output logic       md_busy
);

  logic [3:0] cnt;

  // load on a mult/div leaving E (load beats decrement), else count down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (md_op_E == MD_MULT) begin
      cnt <= 4'(MULT_CYCLES);
    end else if (md_op_E == MD_DIV) begin
      cnt <= 4'(DIV_CYCLES);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign md_busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: in-flight dest scoreboard for E/M/W, stall and forwarding.
// All outputs are combinational from D inputs and the current records (0 cycles).
// stall freezes PC/F-D and turns the incoming E record into a bubble.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] md_op_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic       md_busy
);

  logic [4:0] rs_E, rt_E, wa_E;
  lat_t       tnew_E;
  logic [1:0] md_op_E;
  logic [4:0] rt_M, wa_M;
  lat_t       tnew_M;
  logic [4:0] wa_W;
  logic       hz_rs, hz_rt, hz_md;

  // operand r cannot be satisfied in time by a pending E or M result
  function automatic logic reg_hazard(input logic [4:0] r, input lat_t tuse,
                                      input logic [4:0] wa_e, input lat_t tnew_e,
                                      input logic [4:0] wa_m, input lat_t tnew_m);
    return (r != 5'd0) && (tuse != TUSE_NONE) &&
           (((wa_e == r) && (tnew_e > tuse)) || ((wa_m == r) && (tnew_m > tuse)));
  endfunction

  // D-stage source pick: youngest ready result first, W results are always ready
  function automatic logic [1:0] fwd_sel_d(input logic [4:0] r,
                                           input logic [4:0] wa_e, input lat_t tnew_e,
                                           input logic [4:0] wa_m, input lat_t tnew_m,
                                           input logic [4:0] wa_w);
    if (r == 5'd0)                           return FWD_GRF;
    else if ((wa_e == r) && (tnew_e == '0))  return FWD_E;
    else if ((wa_m == r) && (tnew_m == '0))  return FWD_M;
    else if (wa_w == r)                      return FWD_W;
    else                                     return FWD_GRF;
  endfunction

  // E-stage source pick: M result if ready, else W
  function automatic logic [1:0] fwd_sel_e(input logic [4:0] r,
                                           input logic [4:0] wa_m, input lat_t tnew_m,
                                           input logic [4:0] wa_w);
    if (r == 5'd0)                           return FWD_GRF;
    else if ((wa_m == r) && (tnew_m == '0))  return FWD_M;
    else if (wa_w == r)                      return FWD_W;
    else                                     return FWD_GRF;
  endfunction

  // E record takes the D instruction, or a bubble while D is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset || stall) begin
      rs_E    <= 5'd0;
      rt_E    <= 5'd0;
      wa_E    <= 5'd0;
      tnew_E  <= '0;
      md_op_E <= MD_NONE;
    end else begin
      rs_E    <= rs_D;
      rt_E    <= rt_D;
      wa_E    <= wa_D;
      tnew_E  <= tnew_D;
      md_op_E <= md_op_D;
    end
  end

  // M and W records advance every cycle regardless of stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_M   <= 5'd0;
      wa_M   <= 5'd0;
      tnew_M <= '0;
      wa_W   <= 5'd0;
    end else begin
      rt_M   <= rt_E;
      wa_M   <= wa_E;
      tnew_M <= tnew_dec(tnew_E);
      wa_W   <= wa_M;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .md_op_E (md_op_E),
    .md_busy (md_busy)
  );

  // stall on an unready register operand or on HI/LO use behind a mult/div
  always_comb begin
    hz_rs = reg_hazard(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M);
    hz_rt = reg_hazard(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
    hz_md = md_use_D && (md_busy || (md_op_E != MD_NONE));
    stall = hz_rs || hz_rt || hz_md;
  end

  // forwarding selects for the D compare, E ALU and M store data
  always_comb begin
    fwd_rs_D = fwd_sel_d(rs_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
    fwd_rt_D = fwd_sel_d(rt_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
    fwd_rs_E = fwd_sel_e(rs_E, wa_M, tnew_M, wa_W);
    fwd_rt_E = fwd_sel_e(rt_E, wa_M, tnew_M, wa_W);
    fwd_rt_M = (rt_M != 5'd0) && (rt_M == wa_W);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations, monitor compares.
// The model tracks each instruction's age in the pipe and the cycle the mult/div unit frees up.
// The driver holds the D instruction while the model predicts a stall.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [1:0] md_op;
    logic       md_use;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [1:0] fwd_rs_E;
    logic [1:0] fwd_rt_E;
    logic       fwd_rt_M;
    logic       md_busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_D = '0, rt_D = '0, wa_D = '0;
  logic [1:0] tuse_rs_D = '0, tuse_rt_D = '0, tnew_D = '0, md_op_D = '0;
  logic       md_use_D = 1'b0;
  logic       stall, fwd_rt_M, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wa_D(wa_D), .tnew_D(tnew_D), .md_op_D(md_op_D), .md_use_D(md_use_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // pipe[0]=E, pipe[1]=M, pipe[2]=W; an instruction's age equals its index
  instr_t pipe [3];
  instr_t cur;
  logic   cur_stall = 1'b0;
  int     cyc = 0;
  int     busy_end = -1;   // last cycle in which the mult/div unit is busy

  function automatic int remaining(input instr_t i, input int age);
    return (int'(i.tnew) > age) ? int'(i.tnew) - age : 0;
  endfunction

  function automatic logic needs_wait(input logic [4:0] r, input logic [1:0] tuse);
    logic w = 1'b0;
    if (r != 0 && tuse != 2'd3)
      for (int k = 0; k < 2; k++)
        if (pipe[k].wa == r && remaining(pipe[k], k) > int'(tuse)) w = 1'b1;
    return w;
  endfunction

  // first stage (searching from `from` toward W) holding a ready value for r
  function automatic logic [1:0] source_of(input logic [4:0] r, input int from);
    logic [1:0] s = 2'd0;
    bit found = 0;
    if (r != 0)
      for (int k = from; k < 3; k++)
        if (!found && pipe[k].wa == r && remaining(pipe[k], k) == 0) begin
          s = 2'(3 - k);   // E->3, M->2, W->1
          found = 1;
        end
    return s;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic busy;
    busy = (cyc <= busy_end);
    e.md_busy  = busy;
    e.stall    = needs_wait(cur.rs, cur.tuse_rs) || needs_wait(cur.rt, cur.tuse_rt) ||
                 (cur.md_use && (busy || pipe[0].md_op != 0));
    e.fwd_rs_D = source_of(cur.rs, 0);
    e.fwd_rt_D = source_of(cur.rt, 0);
    e.fwd_rs_E = source_of(pipe[0].rs, 1);
    e.fwd_rt_E = source_of(pipe[0].rt, 1);
    e.fwd_rt_M = (source_of(pipe[1].rt, 2) != 2'd0);
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    busy_end = -1;
  endtask

  task automatic model_advance();
    if (pipe[0].md_op == 2'd1) busy_end = cyc + MULT_N;
    else if (pipe[0].md_op == 2'd2) busy_end = cyc + DIV_N;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = cur_stall ? '0 : cur;
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input instr_t d, input logic rst_val, input bit mid_reset);
    exp_t e;
    @(posedge clk);
    if (reset) begin model_clear(); cyc++; end
    else model_advance();
    #1;
    rs_D = d.rs; rt_D = d.rt; tuse_rs_D = d.tuse_rs; tuse_rt_D = d.tuse_rt;
    wa_D = d.wa; tnew_D = d.tnew; md_op_D = d.md_op; md_use_D = d.md_use;
    reset = rst_val;
    if (rst_val) model_clear();
    if (mid_reset) begin
      #2;
      reset = 1'b1;
      model_clear();
    end
    cur = d;
    e = predict();
    cur_stall = e.stall;
    exp_q.push_back(e);
  endtask

  // present d until the model says it has left D
  task automatic issue(input instr_t d);
    int n = 0;
    do begin
      cycle(d, 1'b0, 1'b0);
      n++;
    end while (cur_stall && n < 20);
    if (cur_stall) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_bound t=%0t actual=stalled_20_cycles required=leaves_D", $time);
    end
  endtask

  function automatic instr_t mk(input int rs, input int rt, input int trs, input int trt,
                                input int wa, input int tn, input int mop, input int muse);
    instr_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.tuse_rs = 2'(trs); i.tuse_rt = 2'(trt);
    i.wa = 5'(wa); i.tnew = 2'(tn); i.md_op = 2'(mop); i.md_use = 1'(muse);
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    i.rs = 5'($urandom_range(0, 3));
    i.rt = 5'($urandom_range(0, 3));
    i.tuse_rs = 2'($urandom_range(0, 3));
    i.tuse_rt = 2'($urandom_range(0, 3));
    i.wa = 5'($urandom_range(0, 3));
    i.tnew = 2'($urandom_range(0, 2));
    i.md_op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
    i.md_use = (i.md_op != 0) || ($urandom_range(0, 5) == 0);
    return i;
  endfunction

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",    {1'b0, stall},    {1'b0, e.stall});
        chk("md_busy",  {1'b0, md_busy},  {1'b0, e.md_busy});
        chk("fwd_rs_D", fwd_rs_D,         e.fwd_rs_D);
        chk("fwd_rt_D", fwd_rt_D,         e.fwd_rt_D);
        chk("fwd_rs_E", fwd_rs_E,         e.fwd_rs_E);
        chk("fwd_rt_E", fwd_rt_E,         e.fwd_rt_E);
        chk("fwd_rt_M", {1'b0, fwd_rt_M}, {1'b0, e.fwd_rt_M});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t nop;
    nop = mk(0, 0, 3, 3, 0, 0, 0, 0);
    model_clear();
    cur = '0;

    // reset held: outputs must stay 0 whatever D presents
    for (int i = 0; i < 3; i++) cycle(rnd(), 1'b1, 1'b0);
    cycle(nop, 1'b0, 1'b0);

    // load-use: lw $1 ; add $2,$1,$3
    issue(mk(29, 0, 1, 3, 1, 2, 0, 0));
    issue(mk(1, 3, 1, 1, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) issue(nop);

    // ALU result into a branch: add $4 ; beq $4,$0
    issue(mk(5, 6, 1, 1, 4, 1, 0, 0));
    issue(mk(4, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) issue(nop);

    // jal ; jr $31
    issue(mk(0, 0, 3, 3, 31, 0, 0, 0));
    issue(mk(31, 0, 0, 3, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) issue(nop);

    // mult ; mfhi ; then store using the mfhi result
    issue(mk(8, 9, 1, 1, 0, 0, 1, 1));
    issue(mk(0, 0, 3, 3, 10, 1, 0, 1));
    issue(mk(29, 10, 1, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) issue(nop);

    // load to $0 then a use of $0
    issue(mk(7, 0, 1, 3, 0, 2, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) issue(nop);

    // div, wait until the count reaches 7, then reset in the middle of the cycle
    issue(mk(8, 9, 1, 1, 0, 0, 2, 1));
    for (int i = 0; i < 4; i++) issue(nop);
    cycle(mk(0, 0, 3, 3, 11, 1, 0, 1), 1'b0, 1'b1);
    cycle(nop, 1'b1, 1'b0);
    cycle(nop, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) issue(rnd());

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
